tlb_maint_engine: RTL

Multi-cycle TLB maintenance sequencer that executes TLBSRCH, TLBRD, TLBWR and TLBFILL.
- Source operands: the TLBEHI, ASID, TLBIDX and TLBELO0/1 CSR values.
- Drives the read and write ports of the external TLB array.
- Returns results to the CSR file. For TLBRD it pulses tlbrd_en/tlb_vpn, which is the consumer side of the TLBEHI update path.
- Sits between the CSR/exception stage and the TLB array.

---
 rtl/tlb_pkg.sv | 33 +++
 rtl/tlb_maint_engine_if.sv | 36 +++
 rtl/tlb_entry_match.sv | 31 +++
 rtl/tlb_maint_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB maintenance engine and the TLB lookup path.
//   - op encodings carried on cmd_op
//   - CSR field positions (TLBEHI.VPPN, TLBIDX.PS/NE, TLBELO.G)
//   - PS_4M: page size whose VPPN compare ignores the low 9 bits
//   - engine FSM state enum
package tlb_pkg;

    typedef enum logic [1:0] {
        OpSrch = 2'd0,
        OpRd   = 2'd1,
        OpWr   = 2'd2,
        OpFill = 2'd3
    } tlb_op_e;

    localparam int unsigned VPPN_MSB = 31;
    localparam int unsigned VPPN_LSB = 13;
    localparam int unsigned PS_MSB   = 29;
    localparam int unsigned PS_LSB   = 24;
    localparam int unsigned NE_BIT   = 31;
    localparam int unsigned G_BIT    = 6;

    localparam logic [5:0] PS_4M = 6'd21;

    typedef enum logic [2:0] {
        StIdle,
        StSrch,
        StRd,
        StRdRsp,
        StWr,
        StDone
    } tlb_state_e;

endpackage

// File: rtl/tlb_maint_engine_if.sv
// tlb_maint_engine_if: read/write port bundle between the maintenance engine and the TLB array.
//   master (engine): drives tlb_rd_en/tlb_rd_idx and the tlb_we/tlb_w_* write port,
//                    receives tlb_rd_* entry fields (valid one cycle after tlb_rd_en).
//   slave  (array) : the mirror image.
interface tlb_maint_engine_if #(
    parameter int unsigned IDXW = 4
);
    logic            tlb_rd_en;
    logic [IDXW-1:0] tlb_rd_idx;
    logic            tlb_rd_e;
    logic            tlb_rd_g;
    logic [18:0]     tlb_rd_vppn;
    logic [5:0]      tlb_rd_ps;
    logic [9:0]      tlb_rd_asid;

    logic            tlb_we;
    logic [IDXW-1:0] tlb_w_idx;
    logic            tlb_w_e;
    logic            tlb_w_g;
    logic [18:0]     tlb_w_vppn;
    logic [5:0]      tlb_w_ps;
    logic [9:0]      tlb_w_asid;

    modport master (
        output tlb_rd_en, tlb_rd_idx,
        input  tlb_rd_e, tlb_rd_g, tlb_rd_vppn, tlb_rd_ps, tlb_rd_asid,
        output tlb_we, tlb_w_idx, tlb_w_e, tlb_w_g, tlb_w_vppn, tlb_w_ps, tlb_w_asid
    );

    modport slave (
        input  tlb_rd_en, tlb_rd_idx,
        output tlb_rd_e, tlb_rd_g, tlb_rd_vppn, tlb_rd_ps, tlb_rd_asid,
        input  tlb_we, tlb_w_idx, tlb_w_e, tlb_w_g, tlb_w_vppn, tlb_w_ps, tlb_w_asid
    );

endinterface

// File: rtl/tlb_entry_match.sv
// tlb_entry_match: combinational hit test of one TLB entry against a VPPN/ASID query.
//   e, g, vppn, ps, asid : entry fields
//   q_vppn, q_asid       : query
//   match                : e && (g || asid match) && VPPN match
// A 4M page (ps == PS_4M) compares only VPPN[18:9].
module tlb_entry_match
    import tlb_pkg::*;
(
    input  logic        e,
    input  logic        g,
    input  logic [18:0] vppn,
    input  logic [5:0]  ps,
    input  logic [9:0]  asid,
    input  logic [18:0] q_vppn,
    input  logic [9:0]  q_asid,
    output logic        match
);

    logic vppn_eq;

    always_comb begin
        vppn_eq = 1'b0;
        if (ps == PS_4M) begin
            vppn_eq = (vppn[18:9] == q_vppn[18:9]);
        end else begin
            vppn_eq = (vppn == q_vppn);
        end
        match = e && (g || (asid == q_asid)) && vppn_eq;
    end

endmodule

// File: rtl/tlb_maint_engine.sv
// tlb_maint_engine: multi-cycle sequencer for TLBSRCH / TLBRD / TLBWR / TLBFILL.
//   clk, rst_n              : clock, asynchronous active-low reset
//   cmd_vld/cmd_op/cmd_rdy  : command handshake (accepted on cmd_vld && cmd_rdy)
//   flush                   : abort an in-flight SRCH or RD
//   csr_*                   : TLBEHI, ASID, TLBIDX, TLBELO0/1 operands, sampled at accept
//   tlbr_mode               : TLB-refill context, forces E=1 on write
//   tlb                     : TLB array read/write port (master side)
//   done                    : one-cycle completion pulse
//   srch_hit/srch_idx       : SRCH result, held until the next SRCH completes
//   tlbrd_en, tlb_vpn, rd_* : RD result pulse and fields, held until the next RD completes
module tlb_maint_engine
    import tlb_pkg::*;
#(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDXW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_vld,
    input  logic [1:0]          cmd_op,
    output logic                cmd_rdy,
    input  logic                flush,
    input  logic [31:0]         csr_tlbehi,
    input  logic [9:0]          csr_asid,
    input  logic [31:0]         csr_tlbidx,
    input  logic [31:0]         csr_tlbelo0,
    input  logic [31:0]         csr_tlbelo1,
    input  logic                tlbr_mode,
    tlb_maint_engine_if.master  tlb,
    output logic                done,
    output logic                srch_hit,
    output logic [IDXW-1:0]     srch_idx,
    output logic                tlbrd_en,
    output logic [18:0]         tlb_vpn,
    output logic [5:0]          rd_ps,
    output logic [9:0]          rd_asid,
    output logic                rd_ne
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

    tlb_state_e      state_q;
    logic [18:0]     vppn_q;
    logic [9:0]      asid_q;
    logic [IDXW-1:0] fill_ptr_q;
    // Index whose array data is on tlb_rd_* this cycle.
    logic            cmp_vld_q;
    logic [IDXW-1:0] cmp_idx_q;
    logic            entry_hit;

    logic unused_csr;
    assign unused_csr = ^{csr_tlbehi[VPPN_LSB-1:0], csr_tlbidx[30], csr_tlbidx[PS_LSB-1:IDXW],
                          csr_tlbelo0[31:G_BIT+1], csr_tlbelo0[G_BIT-1:0],
                          csr_tlbelo1[31:G_BIT+1], csr_tlbelo1[G_BIT-1:0]};

    tlb_entry_match u_entry_match (
        .e      (tlb.tlb_rd_e),
        .g      (tlb.tlb_rd_g),
        .vppn   (tlb.tlb_rd_vppn),
        .ps     (tlb.tlb_rd_ps),
        .asid   (tlb.tlb_rd_asid),
        .q_vppn (vppn_q),
        .q_asid (asid_q),
        .match  (entry_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cmd_rdy        <= 1'b1;
            vppn_q         <= '0;
            asid_q         <= '0;
            fill_ptr_q     <= '0;
            cmp_vld_q      <= 1'b0;
            cmp_idx_q      <= '0;
            tlb.tlb_rd_en  <= 1'b0;
            tlb.tlb_rd_idx <= '0;
            tlb.tlb_we     <= 1'b0;
            tlb.tlb_w_idx  <= '0;
            tlb.tlb_w_e    <= 1'b0;
            tlb.tlb_w_g    <= 1'b0;
            tlb.tlb_w_vppn <= '0;
            tlb.tlb_w_ps   <= '0;
            tlb.tlb_w_asid <= '0;
            done           <= 1'b0;
            srch_hit       <= 1'b0;
            srch_idx       <= '0;
            tlbrd_en       <= 1'b0;
            tlb_vpn        <= '0;
            rd_ps          <= '0;
            rd_asid        <= '0;
            rd_ne          <= 1'b0;
        end else begin
            done       <= 1'b0;
            tlbrd_en   <= 1'b0;
            tlb.tlb_we <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    // flush is ignored here: it only targets in-flight commands.
                    if (cmd_vld) begin
                        cmd_rdy <= 1'b0;
                        vppn_q  <= csr_tlbehi[VPPN_MSB:VPPN_LSB];
                        asid_q  <= csr_asid;
                        unique case (tlb_op_e'(cmd_op))
                            OpSrch: begin
                                state_q        <= StSrch;
                                cmp_vld_q      <= 1'b0;
                                tlb.tlb_rd_en  <= 1'b1;
                                tlb.tlb_rd_idx <= '0;
                            end
                            OpRd: begin
                                state_q        <= StRd;
                                tlb.tlb_rd_en  <= 1'b1;
                                tlb.tlb_rd_idx <= csr_tlbidx[IDXW-1:0];
                            end
                            OpWr, OpFill: begin
                                state_q        <= StWr;
                                tlb.tlb_we     <= 1'b1;
                                tlb.tlb_w_e    <= tlbr_mode | ~csr_tlbidx[NE_BIT];
                                tlb.tlb_w_g    <= csr_tlbelo0[G_BIT] & csr_tlbelo1[G_BIT];
                                tlb.tlb_w_vppn <= csr_tlbehi[VPPN_MSB:VPPN_LSB];
                                tlb.tlb_w_ps   <= csr_tlbidx[PS_MSB:PS_LSB];
                                tlb.tlb_w_asid <= csr_asid;
                                if (tlb_op_e'(cmd_op) == OpFill) begin
                                    tlb.tlb_w_idx <= fill_ptr_q;
                                    fill_ptr_q    <= fill_ptr_q + IDXW'(1);
                                end else begin
                                    tlb.tlb_w_idx <= csr_tlbidx[IDXW-1:0];
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                StSrch: begin
                    cmp_vld_q <= tlb.tlb_rd_en;
                    cmp_idx_q <= tlb.tlb_rd_idx;
                    if (flush) begin
                        state_q       <= StIdle;
                        cmd_rdy       <= 1'b1;
                        cmp_vld_q     <= 1'b0;
                        tlb.tlb_rd_en <= 1'b0;
                    end else if (cmp_vld_q && entry_hit) begin
                        // Reads already issued beyond this index are simply dropped.
                        state_q       <= StDone;
                        done          <= 1'b1;
                        srch_hit      <= 1'b1;
                        srch_idx      <= cmp_idx_q;
                        cmp_vld_q     <= 1'b0;
                        tlb.tlb_rd_en <= 1'b0;
                    end else if (cmp_vld_q && (cmp_idx_q == LAST_IDX)) begin
                        state_q   <= StDone;
                        done      <= 1'b1;
                        srch_hit  <= 1'b0;
                        srch_idx  <= '0;
                        cmp_vld_q <= 1'b0;
                    end else if (tlb.tlb_rd_en) begin
                        if (tlb.tlb_rd_idx == LAST_IDX) begin
                            tlb.tlb_rd_en <= 1'b0;
                        end else begin
                            tlb.tlb_rd_idx <= tlb.tlb_rd_idx + IDXW'(1);
                        end
                    end
                end

                StRd: begin
                    tlb.tlb_rd_en <= 1'b0;
                    if (flush) begin
                        state_q <= StIdle;
                        cmd_rdy <= 1'b1;
                    end else begin
                        state_q <= StRdRsp;
                    end
                end

                StRdRsp: begin
                    if (flush) begin
                        state_q <= StIdle;
                        cmd_rdy <= 1'b1;
                    end else begin
                        state_q  <= StDone;
                        done     <= 1'b1;
                        tlbrd_en <= 1'b1;
                        if (tlb.tlb_rd_e) begin
                            tlb_vpn <= tlb.tlb_rd_vppn;
                            rd_ps   <= tlb.tlb_rd_ps;
                            rd_asid <= tlb.tlb_rd_asid;
                            rd_ne   <= 1'b0;
                        end else begin
                            tlb_vpn <= '0;
                            rd_ps   <= '0;
                            rd_asid <= '0;
                            rd_ne   <= 1'b1;
                        end
                    end
                end

                // Write already committed on entry; flush is deliberately not honoured.
                StWr: begin
                    state_q <= StDone;
                    done    <= 1'b1;
                end

                StDone: begin
                    state_q <= StIdle;
                    cmd_rdy <= 1'b1;
                end

                default: begin
                    state_q <= StIdle;
                    cmd_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule
